// File: rtl/mem_arbiter_2p_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_2p_if
// Purpose  : Bundles both requester ports and the RAM pins of mem_arbiter_2p.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_2p_if #(
    parameter int WIDTH     = 8,
    parameter int ADDR_SIZE = 10
);
    logic                 a_req;
    logic                 a_wen;
    logic [ADDR_SIZE-1:0] a_addr;
    logic [WIDTH-1:0]     a_wdata;
    logic                 a_ack;
    logic                 a_rvalid;
    logic [WIDTH-1:0]     a_rdata;

    logic                 b_req;
    logic                 b_wen;
    logic [ADDR_SIZE-1:0] b_addr;
    logic [WIDTH-1:0]     b_wdata;
    logic                 b_ack;
    logic                 b_rvalid;
    logic [WIDTH-1:0]     b_rdata;

    logic                 mem_cs;
    logic                 mem_wen;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WIDTH-1:0]     mem_din;
    logic [WIDTH-1:0]     mem_dout;

    // Environment side: the two requesters plus the RAM read-data pin.
    modport master (
        output a_req, a_wen, a_addr, a_wdata,
        input  a_ack, a_rvalid, a_rdata,
        output b_req, b_wen, b_addr, b_wdata,
        input  b_ack, b_rvalid, b_rdata,
        input  mem_cs, mem_wen, mem_addr, mem_din,
        output mem_dout
    );

    // Arbiter side.
    modport slave (
        input  a_req, a_wen, a_addr, a_wdata,
        output a_ack, a_rvalid, a_rdata,
        input  b_req, b_wen, b_addr, b_wdata,
        output b_ack, b_rvalid, b_rdata,
        output mem_cs, mem_wen, mem_addr, mem_din,
        input  mem_dout
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_2p
// Purpose  : Two-port round-robin / fixed-priority arbiter for a 1-cycle RAM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_2p #(
    parameter int WIDTH      = 8,
    parameter int ADDR_SIZE  = 10,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clk,
    input  logic                reset,
    mem_arbiter_2p_if.slave     bus
);
    typedef enum logic [0:0] {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam logic c_fixed_prio = (FIXED_PRIO != 0);

    port_e                r_last_grant;
    port_e                r_rd_tag_port;
    logic                 r_rd_tag_v;
    logic [WIDTH-1:0]     r_a_rdata_hold;
    logic [WIDTH-1:0]     r_b_rdata_hold;

    logic                 w_grant_a;
    logic                 w_grant_b;
    logic                 w_a_rvalid;
    logic                 w_b_rvalid;
    logic [ADDR_SIZE-1:0] w_mem_addr;
    logic [WIDTH-1:0]     w_mem_din;

    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!reset) begin
            if (bus.a_req && bus.b_req) begin
                // Contention: A wins when fixed, otherwise whoever did not win last.
                if (c_fixed_prio || (r_last_grant == PORT_B)) begin
                    w_grant_a = 1'b1;
                end else begin
                    w_grant_b = 1'b1;
                end
            end else begin
                w_grant_a = bus.a_req;
                w_grant_b = bus.b_req;
            end
        end
    end

    // Idle cycles keep port A on the address/data pins to avoid toggling.
    assign w_mem_addr   = w_grant_b ? bus.b_addr  : bus.a_addr;
    assign w_mem_din    = w_grant_b ? bus.b_wdata : bus.a_wdata;

    assign bus.a_ack    = w_grant_a;
    assign bus.b_ack    = w_grant_b;
    assign bus.mem_cs   = w_grant_a | w_grant_b;
    assign bus.mem_wen  = (w_grant_a & bus.a_wen) | (w_grant_b & bus.b_wen);
    assign bus.mem_addr = w_mem_addr;
    assign bus.mem_din  = w_mem_din;

    // Reset in the return cycle suppresses the pending read strobe.
    assign w_a_rvalid   = r_rd_tag_v & (r_rd_tag_port == PORT_A) & ~reset;
    assign w_b_rvalid   = r_rd_tag_v & (r_rd_tag_port == PORT_B) & ~reset;

    assign bus.a_rvalid = w_a_rvalid;
    assign bus.b_rvalid = w_b_rvalid;
    assign bus.a_rdata  = w_a_rvalid ? bus.mem_dout : r_a_rdata_hold;
    assign bus.b_rdata  = w_b_rvalid ? bus.mem_dout : r_b_rdata_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant   <= PORT_B;
            r_rd_tag_v     <= 1'b0;
            r_rd_tag_port  <= PORT_A;
            r_a_rdata_hold <= '0;
            r_b_rdata_hold <= '0;
        end else begin
            if (w_grant_a) begin
                r_last_grant <= PORT_A;
            end else if (w_grant_b) begin
                r_last_grant <= PORT_B;
            end
            r_rd_tag_v    <= bus.mem_cs & ~bus.mem_wen;
            r_rd_tag_port <= w_grant_b ? PORT_B : PORT_A;
            if (w_a_rvalid) begin
                r_a_rdata_hold <= bus.mem_dout;
            end
            if (w_b_rvalid) begin
                r_b_rdata_hold <= bus.mem_dout;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter_2p
// Purpose  : Directed table plus random traffic on round-robin and fixed DUTs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_2p;
    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_rst = 1'b1;
    logic       s_ar = 1'b0, s_aw = 1'b0, s_br = 1'b0, s_bw = 1'b0;
    logic [9:0] s_aa = '0, s_ba = '0;
    logic [7:0] s_ad = '0, s_bd = '0;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter_2p_if #(.WIDTH(8), .ADDR_SIZE(10)) if0 ();
    mem_arbiter_2p_if #(.WIDTH(8), .ADDR_SIZE(10)) if1 ();

    mem_arbiter_2p #(.WIDTH(8), .ADDR_SIZE(10), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .reset(s_rst), .bus(if0.slave));
    mem_arbiter_2p #(.WIDTH(8), .ADDR_SIZE(10), .FIXED_PRIO(1)) dut_fix (
        .clk(clk), .reset(s_rst), .bus(if1.slave));

    assign if0.a_req = s_ar;  assign if0.a_wen = s_aw;  assign if0.a_addr = s_aa;  assign if0.a_wdata = s_ad;
    assign if0.b_req = s_br;  assign if0.b_wen = s_bw;  assign if0.b_addr = s_ba;  assign if0.b_wdata = s_bd;
    assign if1.a_req = s_ar;  assign if1.a_wen = s_aw;  assign if1.a_addr = s_aa;  assign if1.a_wdata = s_ad;
    assign if1.b_req = s_br;  assign if1.b_wen = s_bw;  assign if1.b_addr = s_ba;  assign if1.b_wdata = s_bd;

    function automatic logic [7:0] init_val(input int a);
        case (a)
            5:       return 8'h3C;
            16:      return 8'h11;
            32:      return 8'h22;
            default: return 8'(a) ^ 8'h5A;
        endcase
    endfunction

    // Behavioural single-port RAMs, one per DUT, filled on the first edge.
    logic [7:0] ram [2][1024];
    logic [7:0] rd0 = '0, rd1 = '0;
    bit         ram_ready = 1'b0;
    assign if0.mem_dout = rd0;
    assign if1.mem_dout = rd1;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) begin
                ram[0][i] <= init_val(i);
                ram[1][i] <= init_val(i);
            end
            ram_ready <= 1'b1;
        end else begin
            if (if0.mem_cs) begin
                if (if0.mem_wen) ram[0][if0.mem_addr] <= if0.mem_din;
                else             rd0 <= ram[0][if0.mem_addr];
            end
            if (if1.mem_cs) begin
                if (if1.mem_wen) ram[1][if1.mem_addr] <= if1.mem_din;
                else             rd1 <= ram[1][if1.mem_addr];
            end
        end
    end

    // Reference model state: d=0 round-robin DUT, d=1 fixed-priority DUT.
    logic [7:0] mram [2][1024];
    int         m_last  [2];
    bit         m_pv    [2];
    int         m_pport [2];
    logic [7:0] m_pdata [2];

    typedef struct packed {
        logic       rst;
        logic       ar, aw; logic [9:0] aa; logic [7:0] ad;
        logic       br, bw; logic [9:0] ba; logic [7:0] bd;
        logic       e_aa, e_ba, e_rva, e_rvb;
        logic [7:0] e_rd;
    } vec_t;

    localparam int c_nrows = 18;
    vec_t tab [c_nrows];

    function automatic vec_t mk(input logic rst, input logic ar, input logic aw, input logic [9:0] aa,
                                input logic [7:0] ad, input logic br, input logic bw, input logic [9:0] ba,
                                input logic [7:0] bd, input logic eaa, input logic eba, input logic erva,
                                input logic ervb, input logic [7:0] erd);
        vec_t v;
        v.rst = rst; v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
        v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
        v.e_aa = eaa; v.e_ba = eba; v.e_rva = erva; v.e_rvb = ervb; v.e_rd = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        s_rst = v.rst;
        s_ar = v.ar; s_aw = v.aw; s_aa = v.aa; s_ad = v.ad;
        s_br = v.br; s_bw = v.bw; s_ba = v.ba; s_bd = v.bd;
    endtask

    // One clock cycle: sample at negedge, check both DUTs against the model, advance.
    task automatic cycle(input bit use_tab, input int row);
        logic       aa, ba, cs, wen, rva, rvb;
        logic [9:0] addr;
        logic [7:0] din, ard, brd;
        int         win;
        logic       e_wen;
        logic [9:0] e_addr;
        logic [7:0] e_din;
        bit         e_rva, e_rvb;
        string      p;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                aa = if0.a_ack; ba = if0.b_ack; cs = if0.mem_cs; wen = if0.mem_wen; addr = if0.mem_addr;
                din = if0.mem_din; rva = if0.a_rvalid; rvb = if0.b_rvalid; ard = if0.a_rdata; brd = if0.b_rdata;
                p = "rr";
            end else begin
                aa = if1.a_ack; ba = if1.b_ack; cs = if1.mem_cs; wen = if1.mem_wen; addr = if1.mem_addr;
                din = if1.mem_din; rva = if1.a_rvalid; rvb = if1.b_rvalid; ard = if1.a_rdata; brd = if1.b_rdata;
                p = "fix";
            end
            // win: 0 none, 1 port A, 2 port B
            if (s_rst)              win = 0;
            else if (s_ar && s_br)  win = (d == 1) ? 1 : ((m_last[d] == 0) ? 2 : 1);
            else if (s_ar)          win = 1;
            else if (s_br)          win = 2;
            else                    win = 0;
            e_wen  = (win == 1) ? s_aw : ((win == 2) ? s_bw : 1'b0);
            e_addr = (win == 2) ? s_ba : s_aa;
            e_din  = (win == 2) ? s_bd : s_ad;
            e_rva  = !s_rst && m_pv[d] && (m_pport[d] == 0);
            e_rvb  = !s_rst && m_pv[d] && (m_pport[d] == 1);

            chk({p, ".a_ack"},    32'(aa),  32'(win == 1));
            chk({p, ".b_ack"},    32'(ba),  32'(win == 2));
            chk({p, ".mem_cs"},   32'(cs),  32'(win != 0));
            chk({p, ".mem_wen"},  32'(wen), 32'(e_wen));
            chk({p, ".a_rvalid"}, 32'(rva), 32'(e_rva));
            chk({p, ".b_rvalid"}, 32'(rvb), 32'(e_rvb));
            if (win != 0)          chk({p, ".mem_addr"}, 32'(addr), 32'(e_addr));
            if (win != 0 && e_wen) chk({p, ".mem_din"},  32'(din),  32'(e_din));
            if (e_rva)             chk({p, ".a_rdata"},  32'(ard),  32'(m_pdata[d]));
            if (e_rvb)             chk({p, ".b_rdata"},  32'(brd),  32'(m_pdata[d]));

            if (s_rst) begin
                m_last[d] = 1;
                m_pv[d]   = 1'b0;
            end else begin
                m_pv[d] = (win != 0) && !e_wen;
                if (win != 0) begin
                    m_last[d]  = win - 1;
                    m_pport[d] = win - 1;
                    m_pdata[d] = mram[d][e_addr];
                    if (e_wen) mram[d][e_addr] = e_din;
                end
            end
        end
        if (use_tab) begin
            chk($sformatf("tab%0d.a_ack", row),    32'(if0.a_ack),    32'(tab[row].e_aa));
            chk($sformatf("tab%0d.b_ack", row),    32'(if0.b_ack),    32'(tab[row].e_ba));
            chk($sformatf("tab%0d.a_rvalid", row), 32'(if0.a_rvalid), 32'(tab[row].e_rva));
            chk($sformatf("tab%0d.b_rvalid", row), 32'(if0.b_rvalid), 32'(tab[row].e_rvb));
            if (tab[row].e_rva) chk($sformatf("tab%0d.a_rdata", row), 32'(if0.a_rdata), 32'(tab[row].e_rd));
            if (tab[row].e_rvb) chk($sformatf("tab%0d.b_rdata", row), 32'(if0.b_rdata), 32'(tab[row].e_rd));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mram[0][i] = init_val(i);
            mram[1][i] = init_val(i);
        end
        for (int d = 0; d < 2; d++) begin
            m_last[d] = 1; m_pv[d] = 1'b0; m_pport[d] = 0; m_pdata[d] = '0;
        end

        //             rst ar aw aa      ad     br bw ba      bd     eaa eba rva rvb rd
        tab[0]  = mk(1, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 8'h00);
        tab[1]  = mk(1, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 8'h00);
        tab[2]  = mk(0, 1, 0, 10'h005, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 0, 0, 8'h00);
        tab[3]  = mk(0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 1, 0, 8'h3C);
        tab[4]  = mk(0, 1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00, 0, 1, 0, 0, 8'h00);
        tab[5]  = mk(0, 1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00, 1, 0, 0, 1, 8'h22);
        tab[6]  = mk(0, 1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00, 0, 1, 1, 0, 8'h11);
        tab[7]  = mk(0, 1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00, 1, 0, 0, 1, 8'h22);
        tab[8]  = mk(0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 1, 0, 8'h11);
        tab[9]  = mk(0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 8'h00);
        tab[10] = mk(0, 1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00, 0, 1, 0, 0, 8'h00);
        tab[11] = mk(0, 0, 0, 10'h000, 8'h00, 1, 1, 10'h030, 8'hAA, 0, 1, 0, 1, 8'h22);
        tab[12] = mk(0, 1, 0, 10'h030, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 0, 0, 8'h00);
        tab[13] = mk(0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 1, 0, 8'hAA);
        tab[14] = mk(0, 1, 0, 10'h005, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 0, 0, 8'h00);
        tab[15] = mk(1, 1, 0, 10'h005, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 8'h00);
        tab[16] = mk(0, 1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00, 1, 0, 0, 0, 8'h00);
        tab[17] = mk(0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 1, 0, 8'h11);

        for (int r = 0; r < c_nrows; r++) begin
            apply(tab[r]);
            cycle(1'b1, r);
        end

        // Random traffic on a small address window to provoke conflicts and RAW hazards.
        for (int k = 0; k < 400; k++) begin
            s_rst = ($urandom_range(0, 39) == 0);
            s_ar  = 1'($urandom_range(0, 1));
            s_aw  = 1'($urandom_range(0, 1));
            s_aa  = 10'($urandom_range(0, 15));
            s_ad  = 8'($urandom_range(0, 255));
            s_br  = 1'($urandom_range(0, 1));
            s_bw  = 1'($urandom_range(0, 1));
            s_ba  = 10'($urandom_range(0, 15));
            s_bd  = 8'($urandom_range(0, 255));
            cycle(1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
